// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory-port arbiter: FSM states,
// owner codes and the memory access size codes also used by DataMemory.
package mem_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Value loaded into the latency timer in ISSUE so it reaches zero on the
    // cycle mem_rdata is valid.
    function automatic logic [3:0] lat_load(input int latency);
        return 4'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_latency_timer.sv
// 4-bit loadable down-counter with a zero flag; paces the WAIT state of the
// memory-port arbiter.
module mem_latency_timer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency unified memory between instruction fetch and
// data access (data has priority). Optional stall statistics: MEM_ARB_STATS_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [31:0]       i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_size,
    output logic              mem_unsigned,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       i_wait_cnt,
    output logic [31:0]       d_wait_cnt,
    output logic [1:0]        dbg_state,
    output logic              dbg_owner
);

    localparam logic [3:0] LAT_LOAD = lat_load(MEM_LATENCY);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              abort_q, abort_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic              mem_unsigned_q, mem_unsigned_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              owner_req;
    logic              tmr_zero;

    mem_latency_timer u_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (state_q == ISSUE),
        .en       (state_q == WAIT),
        .load_val (LAT_LOAD),
        .zero     (tmr_zero)
    );

    assign owner_req = (owner_q == OWN_D) ? d_req : i_req;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        abort_d        = abort_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_size_d     = mem_size_q;
        mem_unsigned_d = mem_unsigned_q;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
        i_done_d       = 1'b0;
        d_done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    owner_d        = OWN_D;
                    abort_d        = 1'b0;
                    mem_we_d       = d_we;
                    mem_addr_d     = d_addr;
                    mem_wdata_d    = d_wdata;
                    mem_size_d     = d_size;
                    mem_unsigned_d = d_unsigned;
                    state_d        = ISSUE;
                end else if (i_req) begin
                    owner_d        = OWN_I;
                    abort_d        = 1'b0;
                    mem_we_d       = 1'b0;
                    mem_addr_d     = i_addr;
                    mem_wdata_d    = 32'd0;
                    mem_size_d     = SZ_WORD;
                    mem_unsigned_d = 1'b0;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (!owner_req) abort_d = 1'b0 | 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (!owner_req) abort_d = 1'b1;
                if (tmr_zero) begin
                    state_d = RESP;
                    // A squashed owner lets memory finish but sees no response.
                    if (!abort_q && owner_req) begin
                        if (owner_q == OWN_D) begin
                            d_done_d = 1'b1;
                            if (!mem_we_q) d_rdata_d = mem_rdata;
                        end else begin
                            i_done_d  = 1'b1;
                            i_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= IDLE;
            owner_q        <= OWN_I;
            abort_q        <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 32'd0;
            mem_size_q     <= 2'd0;
            mem_unsigned_q <= 1'b0;
            i_rdata_q      <= 32'd0;
            d_rdata_q      <= 32'd0;
            i_done_q       <= 1'b0;
            d_done_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            abort_q        <= abort_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_size_q     <= mem_size_d;
            mem_unsigned_q <= mem_unsigned_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
            i_done_q       <= i_done_d;
            d_done_q       <= d_done_d;
        end
    end

    assign mem_req      = (state_q == ISSUE);
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_size     = mem_size_q;
    assign mem_unsigned = mem_unsigned_q;
    assign i_done       = i_done_q;
    assign d_done       = d_done_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign i_stall      = i_req & ~i_done_q;
    assign d_stall      = d_req & ~d_done_q;
    assign dbg_state    = state_q;
    assign dbg_owner    = owner_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] i_wait_q, i_wait_d;
    logic [31:0] d_wait_q, d_wait_d;

    // Saturating stall-cycle counters.
    always_comb begin
        i_wait_d = i_wait_q;
        d_wait_d = d_wait_q;
        if (i_stall && (i_wait_q != 32'hFFFF_FFFF)) i_wait_d = i_wait_q + 32'd1;
        if (d_stall && (d_wait_q != 32'hFFFF_FFFF)) d_wait_d = d_wait_q + 32'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            i_wait_q <= 32'd0;
            d_wait_q <= 32'd0;
        end else begin
            i_wait_q <= i_wait_d;
            d_wait_q <= d_wait_d;
        end
    end

    assign i_wait_cnt = i_wait_q;
    assign d_wait_cnt = d_wait_q;
`else
    assign i_wait_cnt = 32'd0;
    assign d_wait_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: fixed-latency memory model,
// scoreboard queues for memory commands and instruction/data responses.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT = 2;
`ifdef MEM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        i_req, d_req, d_we, d_unsigned;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        i_done, i_stall, d_done, d_stall;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_we, mem_unsigned;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    logic [31:0] i_wait_cnt, d_wait_cnt;
    logic [1:0]  dbg_state;
    logic        dbg_owner;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_unsigned(d_unsigned), .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_rdata(mem_rdata),
        .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt),
        .dbg_state(dbg_state), .dbg_owner(dbg_owner)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
    } cmd_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    cmd_t        exp_mem_q[$];
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] i_model = 32'd0;
    logic [31:0] d_model = 32'd0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h40) return 32'h2008000A;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: data valid exactly LAT cycles after the mem_req cycle.
    initial mem_rdata = 32'hDEAD_BEEF;
    always begin
        @(posedge Clk);
        #1;
        cyc++;
        mem_rdata = 32'hDEAD_BEEF;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            mem_rdata = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
        if (mem_req) rsp_q.push_back('{due: cyc + LAT, data: mem_data(mem_addr)});
    end

    // Scoreboard monitor.
    cmd_t        mon_cmd;
    logic [31:0] mon_data;
    always @(negedge Clk) begin
        if (!Reset) begin
            if (mem_req) begin
                if (exp_mem_q.size() == 0) check_eq("mem_req_unexpected", 1, 0);
                else begin
                    mon_cmd = exp_mem_q.pop_front();
                    check_eq("mem_we", mem_we, mon_cmd.we);
                    check_eq("mem_addr", mem_addr, mon_cmd.addr);
                    check_eq("mem_wdata", mem_wdata, mon_cmd.wdata);
                    check_eq("mem_size", mem_size, mon_cmd.size);
                    check_eq("mem_unsigned", mem_unsigned, mon_cmd.uns);
                end
            end
            if (i_done) begin
                if (exp_i_q.size() == 0) check_eq("i_done_unexpected", 1, 0);
                else begin
                    mon_data = exp_i_q.pop_front();
                    check_eq("i_rdata", i_rdata, mon_data);
                end
            end
            if (d_done) begin
                if (exp_d_q.size() == 0) check_eq("d_done_unexpected", 1, 0);
                else begin
                    mon_data = exp_d_q.pop_front();
                    check_eq("d_rdata", d_rdata, mon_data);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_d(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        d_req = req; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size; d_unsigned = uns;
    endtask

    task automatic expect_cmd(input logic is_d, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        cmd_t c;
        c.we    = is_d ? we : 1'b0;
        c.addr  = addr;
        c.wdata = is_d ? wdata : 32'd0;
        c.size  = is_d ? size : SZ_WORD;
        c.uns   = is_d ? uns : 1'b0;
        exp_mem_q.push_back(c);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_i_done"}, i_done, 0);
        check_eq({tag, "_d_done"}, d_done, 0);
        check_eq({tag, "_i_rdata"}, i_rdata, 0);
        check_eq({tag, "_d_rdata"}, d_rdata, 0);
        check_eq({tag, "_i_stall"}, i_stall, 0);
        check_eq({tag, "_d_stall"}, d_stall, 0);
        check_eq({tag, "_mem_req"}, mem_req, 0);
        check_eq({tag, "_mem_fields"}, {mem_we, mem_addr, mem_wdata, mem_size, mem_unsigned}, 0);
        check_eq({tag, "_cnts"}, {i_wait_cnt, d_wait_cnt}, 0);
        check_eq({tag, "_state"}, dbg_state, IDLE);
    endtask

    // One isolated transaction with full cycle-by-cycle timing checks.
    task automatic run_txn(input string tag, input logic is_d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        expect_cmd(is_d, we, addr, wdata, size, uns);
        if (is_d) begin
            if (!we) d_model = mem_data(addr);
            exp_d_q.push_back(d_model);
        end else begin
            i_model = mem_data(addr);
            exp_i_q.push_back(i_model);
        end
        for (int c = 0; c <= LAT + 3; c++) begin
            if (c == 0) begin
                if (is_d) drive_d(1'b1, we, addr, wdata, size, uns);
                else begin i_req = 1'b1; i_addr = addr; end
            end else if (c == LAT + 3) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            @(negedge Clk);
            check_eq({tag, "_mem_req"}, mem_req, (c == 1));
            check_eq({tag, "_done"}, is_d ? d_done : i_done, (c == LAT + 2));
            check_eq({tag, "_other_done"}, is_d ? i_done : d_done, 0);
            check_eq({tag, "_stall"}, is_d ? d_stall : i_stall, (c <= LAT + 1));
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        i_req = 1'b0; i_addr = 32'd0;
        drive_d(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        next_cycle();
        next_cycle();
        @(negedge Clk);
        check_all_zero("reset");
        next_cycle();
        Reset = 1'b0;
        next_cycle();

        // Simultaneous requests: data first, then fetch; also stall statistics.
        expect_cmd(1'b1, 1'b0, 32'h100, 32'd0, SZ_WORD, 1'b0);
        expect_cmd(1'b0, 1'b0, 32'h80, 32'd0, SZ_WORD, 1'b0);
        d_model = mem_data(32'h100);
        exp_d_q.push_back(d_model);
        i_model = mem_data(32'h80);
        exp_i_q.push_back(i_model);
        for (int c = 0; c <= 10; c++) begin
            if (c == 0) begin
                drive_d(1'b1, 1'b0, 32'h100, 32'd0, SZ_WORD, 1'b0);
                i_req = 1'b1; i_addr = 32'h80;
            end
            if (c == 5) d_req = 1'b0;
            if (c == 10) i_req = 1'b0;
            @(negedge Clk);
            check_eq("sim_mem_req", mem_req, (c == 1 || c == 6));
            check_eq("sim_d_done", d_done, (c == 4));
            check_eq("sim_i_done", i_done, (c == 9));
            check_eq("sim_d_stall", d_stall, (c <= 3));
            check_eq("sim_i_stall", i_stall, (c <= 8));
            if (c == 10) begin
                check_eq("stats_i_wait", i_wait_cnt, STATS ? 9 : 0);
                check_eq("stats_d_wait", d_wait_cnt, STATS ? 4 : 0);
            end
            next_cycle();
        end

        run_txn("fetch40", 1'b0, 1'b0, 32'h40, 32'd0, SZ_WORD, 1'b0);
        run_txn("store_b", 1'b1, 1'b1, 32'h103, 32'hAB, SZ_BYTE, 1'b0);
        run_txn("load_h", 1'b1, 1'b0, 32'h202, 32'd0, SZ_HALF, 1'b1);

        // Flush mid-fetch, then a data load right after.
        expect_cmd(1'b0, 1'b0, 32'h44, 32'd0, SZ_WORD, 1'b0);
        expect_cmd(1'b1, 1'b0, 32'h200, 32'd0, SZ_WORD, 1'b0);
        for (int c = 0; c <= 10; c++) begin
            if (c == 0) begin i_req = 1'b1; i_addr = 32'h44; end
            if (c == 2) i_req = 1'b0;
            if (c == 5) begin
                drive_d(1'b1, 1'b0, 32'h200, 32'd0, SZ_WORD, 1'b0);
                d_model = mem_data(32'h200);
                exp_d_q.push_back(d_model);
            end
            if (c == 10) d_req = 1'b0;
            @(negedge Clk);
            check_eq("flush_i_done", i_done, 0);
            check_eq("flush_mem_req", mem_req, (c == 1 || c == 6));
            check_eq("flush_d_done", d_done, (c == 9));
            if (c == 5) check_eq("flush_idle", dbg_state, IDLE);
            if (c == 6) check_eq("flush_i_rdata", i_rdata, i_model);
            next_cycle();
        end

        for (int n = 0; n < 8; n++) begin
            logic        r_d, r_we;
            logic [31:0] r_addr, r_wdata;
            logic [1:0]  r_size;
            r_d     = 1'($urandom_range(0, 1));
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = 32'($urandom_range(0, 4095));
            r_wdata = $urandom;
            r_size  = 2'($urandom_range(0, 2));
            run_txn("rand", r_d, r_we, r_addr, r_wdata, r_size, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a load.
        expect_cmd(1'b1, 1'b0, 32'h300, 32'd0, SZ_WORD, 1'b0);
        for (int c = 0; c <= 5; c++) begin
            if (c == 0) drive_d(1'b1, 1'b0, 32'h300, 32'd0, SZ_WORD, 1'b0);
            if (c == 2) begin
                Reset = 1'b1;
                d_req = 1'b0;
                i_model = 32'd0;
                d_model = 32'd0;
            end
            if (c == 3) Reset = 1'b0;
            @(negedge Clk);
            if (c == 3) check_all_zero("midrst");
            if (c >= 4) begin
                check_eq("midrst_d_done", d_done, 0);
                check_eq("midrst_d_rdata", d_rdata, 0);
                check_eq("midrst_state", dbg_state, IDLE);
            end
            next_cycle();
        end
        run_txn("postrst", 1'b1, 1'b0, 32'h304, 32'd0, SZ_WORD, 1'b0);
        run_txn("postrst_f", 1'b0, 1'b0, 32'h48, 32'd0, SZ_WORD, 1'b0);

        check_eq("queues_drained", exp_mem_q.size() + exp_i_q.size() + exp_d_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
